// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the registered ALU and its issue controller:
//   - FunSel codes for all 32 operations. op[4]=1 selects 32-bit, op[4]=0 selects
//     16-bit with a sign-extended 32-bit result.
//   - Bit positions of Z, C, N and V inside the 4-bit flags bus.
//   - State encoding of the issue controller FSM.
package alu_pkg;

   // 16-bit operations (op[4] = 0)
   localparam logic [4:0] PASSA16 = 5'b00000;
   localparam logic [4:0] PASSB16 = 5'b00001;
   localparam logic [4:0] NOTA16  = 5'b00010;
   localparam logic [4:0] NOTB16  = 5'b00011;
   localparam logic [4:0] ADD16   = 5'b00100;
   localparam logic [4:0] ADDC16  = 5'b00101;
   localparam logic [4:0] SUB16   = 5'b00110;
   localparam logic [4:0] AND16   = 5'b00111;
   localparam logic [4:0] OR16    = 5'b01000;
   localparam logic [4:0] XOR16   = 5'b01001;
   localparam logic [4:0] NAND16  = 5'b01010;
   localparam logic [4:0] LSL16   = 5'b01011;
   localparam logic [4:0] LSR16   = 5'b01100;
   localparam logic [4:0] ASR16   = 5'b01101;
   localparam logic [4:0] CSL16   = 5'b01110;
   localparam logic [4:0] CSR16   = 5'b01111;

   // 32-bit operations (op[4] = 1)
   localparam logic [4:0] PASSA32 = 5'b10000;
   localparam logic [4:0] PASSB32 = 5'b10001;
   localparam logic [4:0] NOTA32  = 5'b10010;
   localparam logic [4:0] NOTB32  = 5'b10011;
   localparam logic [4:0] ADD32   = 5'b10100;
   localparam logic [4:0] ADDC32  = 5'b10101;
   localparam logic [4:0] SUB32   = 5'b10110;
   localparam logic [4:0] AND32   = 5'b10111;
   localparam logic [4:0] OR32    = 5'b11000;
   localparam logic [4:0] XOR32   = 5'b11001;
   localparam logic [4:0] NAND32  = 5'b11010;
   localparam logic [4:0] LSL32   = 5'b11011;
   localparam logic [4:0] LSR32   = 5'b11100;
   localparam logic [4:0] ASR32   = 5'b11101;
   localparam logic [4:0] CSL32   = 5'b11110;
   localparam logic [4:0] CSR32   = 5'b11111;

   // Flag bus layout {Z,C,N,V}
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;

   // Issue controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_EXEC  = 2'd2,
      ST_RESP  = 2'd3
   } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Drives the registered ALU on behalf of the control unit, one operation at a time.
// Each operation runs through the same sequence:
//   1. Prime the ALU carry with the resolved carry-in under a neutral FunSel.
//   2. Hold the real FunSel and the operands steady while the result appears
//      (after RES_LAT edges) and the flags appear (after FLAG_LAT edges).
//   3. Return the captured result and flags over a valid/ready response channel.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op/req_a/req_b      FunSel code and operands for the operation
//   req_use_carry/req_cin   carry-in select: the saved carry or the explicit bit
//   rsp_valid/rsp_ready     response handshake
//   rsp_result/rsp_flags    captured ALUOut and {Z,C,N,V}
//   carry_q                 architectural carry, updated when an operation completes
//   busy                    high in any state except IDLE
//   alu_funsel/a/b/cin      registered drive to the ALU
//   alu_out/alu_flags       ALU outputs (ALUOut, {Z,C,N,V})
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int         RES_LAT        = 1,
   parameter int         FLAG_LAT       = 3,
   parameter logic [4:0] NEUTRAL_FUNSEL = 5'b10000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_use_carry,
   input  logic        req_cin,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic        carry_q,
   output logic        busy,
   output logic [4:0]  alu_funsel,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_cin,
   input  logic [31:0] alu_out,
   input  logic [3:0]  alu_flags
);

   localparam int CNT_W = $clog2(FLAG_LAT + 1);
   localparam logic [CNT_W-1:0] RES_CNT  = CNT_W'(RES_LAT);
   localparam logic [CNT_W-1:0] FLAG_CNT = CNT_W'(FLAG_LAT);

   issue_state_t     state;
   logic [4:0]       op_q;
   logic [CNT_W-1:0] exec_cnt;

   // The request side can only take work while idle, and busy is its complement.
   // Both come straight from the state register, so they carry no combinational
   // path from the inputs.
   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   // Main sequencer.
   // The alu_a/alu_b/alu_cin registers are loaded directly on the accept edge and
   // act as the operand latches. They stay untouched until the next accept, so the
   // ALU sees stable operands through PRIME and the whole EXEC window. The flags
   // lag ALUOut, so the inputs must not move while the flags settle.
   // exec_cnt is cleared on entry to EXEC and reaches 1 on the first EXEC edge.
   // The result is captured while exec_cnt == RES_LAT and the flags while
   // exec_cnt == FLAG_LAT. At that second point the operation completes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         op_q       <= '0;
         exec_cnt   <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         carry_q    <= 1'b0;
         alu_funsel <= NEUTRAL_FUNSEL;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_cin    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q       <= req_op;
                  alu_a      <= req_a;
                  alu_b      <= req_b;
                  alu_cin    <= req_use_carry ? carry_q : req_cin;
                  alu_funsel <= NEUTRAL_FUNSEL;
                  state      <= ST_PRIME;
               end
            end
            ST_PRIME: begin
               alu_funsel <= op_q;
               exec_cnt   <= '0;
               state      <= ST_EXEC;
            end
            ST_EXEC: begin
               exec_cnt <= exec_cnt + CNT_W'(1);
               if (exec_cnt == RES_CNT) begin
                  rsp_result <= alu_out;
               end
               if (exec_cnt == FLAG_CNT) begin
                  rsp_flags <= alu_flags;
                  carry_q   <= alu_flags[FLAG_C];
                  rsp_valid <= 1'b1;
                  exec_cnt  <= '0;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  alu_funsel <= NEUTRAL_FUNSEL;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl. It contains a small behavioural model of the
// registered ALU:
//   - ALUOut appears one edge after FunSel is applied.
//   - The flags pass through two extra stages and appear after three edges.
//   - The internal carry is loaded from cin whenever FunSel is neutral.
// Expected values are hand-computed in the vector table.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        req_use_carry = 1'b0;
   logic        req_cin = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        carry_q;
   logic        busy;
   logic [4:0]  alu_funsel;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_cin;
   logic [31:0] alu_out;
   logic [3:0]  alu_flags;

   int compared   = 0;
   int mismatched = 0;
   int latency    = 0;

   alu_issue_ctrl dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_use_carry(req_use_carry), .req_cin(req_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .carry_q(carry_q), .busy(busy),
      .alu_funsel(alu_funsel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_flags(alu_flags)
   );

   always #5 clock = ~clock;

   // Combinational part of the ALU model, covering the ops the vectors use.
   // Anything else behaves as pass-A with C = cin.
   logic        aluCarry = 1'b0;
   logic [32:0] sum33;
   logic [16:0] sum17;
   logic [31:0] resNow;
   logic        cNow, vNow;
   logic [3:0]  flagsNow;
   always_comb begin
      sum33  = '0;
      sum17  = '0;
      resNow = alu_a;
      cNow   = alu_cin;
      vNow   = 1'b0;
      case (alu_funsel)
         ADD32: begin
            sum33  = {1'b0, alu_a} + {1'b0, alu_b};
            resNow = sum33[31:0];
            cNow   = sum33[32];
            vNow   = (alu_a[31] == alu_b[31]) && (resNow[31] != alu_a[31]);
         end
         ADDC32: begin
            sum33  = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, aluCarry};
            resNow = sum33[31:0];
            cNow   = sum33[32];
            vNow   = (alu_a[31] == alu_b[31]) && (resNow[31] != alu_a[31]);
         end
         SUB32: begin
            sum33  = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            resNow = sum33[31:0];
            cNow   = sum33[32];
            vNow   = (alu_a[31] != alu_b[31]) && (resNow[31] != alu_a[31]);
         end
         ADD16: begin
            sum17  = {1'b0, alu_a[15:0]} + {1'b0, alu_b[15:0]};
            resNow = {{16{sum17[15]}}, sum17[15:0]};
            cNow   = sum17[16];
            vNow   = (alu_a[15] == alu_b[15]) && (sum17[15] != alu_a[15]);
         end
         AND32: resNow = alu_a & alu_b;
         OR32:  resNow = alu_a | alu_b;
         XOR32: resNow = alu_a ^ alu_b;
         CSL32: begin
            resNow = {alu_a[30:0], aluCarry};
            cNow   = alu_a[31];
         end
         default: resNow = alu_a;
      endcase
      flagsNow = {(resNow == 32'd0), cNow, resNow[31], vNow};
   end

   // Registered part of the ALU model: one stage for ALUOut, three for the flags.
   logic [3:0] flagStage1, flagStage2;
   always @(posedge clock) begin
      alu_out    <= resNow;
      flagStage1 <= flagsNow;
      flagStage2 <= flagStage1;
      alu_flags  <= flagStage2;
      if (alu_funsel == 5'b10000) aluCarry <= alu_cin;
   end

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        useCarry;
      logic        cin;
      logic [31:0] expResult;
      logic [3:0]  expFlags;
      logic        expCarry;
   } vector_t;

   vector_t vectors [11];

   // Counts one comparison and reports it when the values differ.
   task automatic checkValue(input string what, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", what, actual, expected);
      end
   endtask

   // Waits, with a bound, for rsp_valid after an accept edge, counting edges.
   task automatic waitResponse();
      latency = 0;
      while (!rsp_valid && latency < 20) begin
         @(posedge clock);
         latency++;
         @(negedge clock);
      end
   endtask

   // Presents one request, waits for it to be accepted, then waits for the response.
   task automatic applyStimulus(input vector_t v);
      int guard;
      @(negedge clock);
      req_op        = v.op;
      req_a         = v.a;
      req_b         = v.b;
      req_use_carry = v.useCarry;
      req_cin       = v.cin;
      req_valid     = 1'b1;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      checkValue("accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      waitResponse();
   endtask

   // Compares the response against the record, completes the handshake and
   // checks the return to idle.
   task automatic checkOutput(input vector_t v, input string tag);
      checkValue({tag, "_valid"},   {31'd0, rsp_valid}, 32'd1);
      checkValue({tag, "_latency"}, 32'(latency), 32'd5);
      checkValue({tag, "_result"},  rsp_result, v.expResult);
      checkValue({tag, "_flags"},   {28'd0, rsp_flags}, {28'd0, v.expFlags});
      checkValue({tag, "_carry"},   {31'd0, carry_q}, {31'd0, v.expCarry});
      rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rsp_ready = 1'b0;
      checkValue({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
      checkValue({tag, "_idle"},       {31'd0, busy}, 32'd0);
      checkValue({tag, "_funsel"},     {27'd0, alu_funsel}, 32'h10);
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vector_t queued;
      bit      stable;
      bit      sawValid;

      vectors[0]  = '{ADD32,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1100, 1'b1};
      vectors[1]  = '{ADDC32, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 4'b0000, 1'b0};
      vectors[2]  = '{ADD16,  32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_8000, 4'b0011, 1'b0};
      vectors[3]  = '{CSL32,  32'h8000_0001, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0003, 4'b0100, 1'b1};
      vectors[4]  = '{AND32,  32'hF0F0_00FF, 32'h0FF0_00F0, 1'b0, 1'b0, 32'h00F0_00F0, 4'b0000, 1'b0};
      vectors[5]  = '{ADDC32, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0031, 4'b0000, 1'b0};
      vectors[6]  = '{XOR32,  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 4'b1000, 1'b0};
      vectors[7]  = '{SUB32,  32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'b0010, 1'b0};
      vectors[8]  = '{ADD32,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0011, 1'b0};
      vectors[9]  = '{ADD32,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 4'b0110, 1'b1};
      vectors[10] = '{OR32,   32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 4'b1100, 1'b1};

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      checkValue("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkValue("rst_busy",      {31'd0, busy}, 32'd0);
      checkValue("rst_req_ready", {31'd0, req_ready}, 32'd1);
      checkValue("rst_carry",     {31'd0, carry_q}, 32'd0);
      checkValue("rst_funsel",    {27'd0, alu_funsel}, 32'h10);
      checkValue("rst_result",    rsp_result, 32'd0);

      // Table-driven vectors. They run in order because the carry chains across them.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vectors[i]);
         checkOutput(vectors[i], $sformatf("vec%0d", i));
      end

      // Backpressure: the response is held while a second request waits.
      applyStimulus('{SUB32, 32'd5, 32'd3, 1'b0, 1'b0, 32'd2, 4'b0100, 1'b1});
      checkValue("bp_valid",   {31'd0, rsp_valid}, 32'd1);
      checkValue("bp_latency", 32'(latency), 32'd5);
      req_op = ADD32; req_a = 32'hFFFF_FFFF; req_b = 32'h0000_0002;
      req_use_carry = 1'b0; req_cin = 1'b0; req_valid = 1'b1;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clock);
         if (!(rsp_valid && rsp_result == 32'd2 && rsp_flags == 4'b0100 && !req_ready && busy))
            stable = 1'b0;
      end
      checkValue("bp_stable", {31'd0, stable}, 32'd1);
      rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rsp_ready = 1'b0;
      checkValue("bp_release_ready", {31'd0, req_ready}, 32'd1);
      checkValue("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      checkValue("bp_queued_accept", {31'd0, busy}, 32'd1);
      waitResponse();
      queued = '{ADD32, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001, 4'b0100, 1'b1};
      checkOutput(queued, "bp_queued");

      // Reset during the second EXEC cycle discards the operation.
      checkValue("pre_reset_carry", {31'd0, carry_q}, 32'd1);
      req_op = ADD32; req_a = 32'hFFFF_FFFF; req_b = 32'h1;
      req_use_carry = 1'b0; req_cin = 1'b0; req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      checkValue("midrst_busy",   {31'd0, busy}, 32'd0);
      checkValue("midrst_carry",  {31'd0, carry_q}, 32'd0);
      checkValue("midrst_funsel", {27'd0, alu_funsel}, 32'h10);
      checkValue("midrst_alu_a",  alu_a, 32'd0);
      sawValid = 1'b0;
      repeat (10) begin
         @(negedge clock);
         if (rsp_valid) sawValid = 1'b1;
      end
      checkValue("midrst_no_rsp", {31'd0, sawValid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator-side controller that drives the registered 32/16-bit ALU (FunSel/input_a/input_b/cin in, ALUOut/flags out) on behalf of the datapath control unit. It accepts one operation at a time over a valid/ready request channel and sequences the ALU through a prime/execute window with fixed latency. It captures ALUOut and the Z|C|N|V flags at the correct edges and returns them over a valid/ready response channel. It also keeps an architectural carry bit for add-with-carry and rotate chains.

Parameters:
RES_LAT, 1, edges after FunSel is first driven at which ALUOut holds the result
FLAG_LAT, 3, edges after FunSel is first driven at which flags matches that result
NEUTRAL_FUNSEL, 5'b10000, FunSel driven when idle or priming (pass A; leaves ALU carry = cin)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept (IDLE only)
req_op  in  5  ALU FunSel code for this operation
req_a  in  32  operand A
req_b  in  32  operand B
req_use_carry  in  1  1: cin = saved carry; 0: cin = req_cin
req_cin  in  1  explicit carry-in
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  captured ALUOut
rsp_flags  out  4  captured {Z,C,N,V}
carry_q  out  1  saved architectural carry
busy  out  1  high in any state except IDLE
alu_funsel  out  5  to ALU FunSel
alu_a  out  32  to ALU input_a
alu_b  out  32  to ALU input_b
alu_cin  out  1  to ALU cin

Behaviour:
- Reset (sync, active-high, any state): state=IDLE; rsp_valid=0; rsp_result=0; rsp_flags=0; carry_q=0; alu_funsel=NEUTRAL_FUNSEL; alu_a=alu_b=0; alu_cin=0; the in-flight op is discarded with no response.
- FSM states: IDLE, PRIME, EXEC, RESP.
- IDLE: req_ready=1. On req_valid: latch op, a, b, and the resolved cin (carry_q or req_cin) into operand registers. Go to PRIME.
- PRIME (1 cycle): alu_a/alu_b/alu_cin are driven from the latched values; alu_funsel=NEUTRAL_FUNSEL. This loads the ALU's internal carry with cin before the real op.
- EXEC: alu_funsel=latched op. A cycle counter starts at 1 on the first EXEC edge. alu_a/alu_b/alu_cin/alu_funsel stay constant for the whole EXEC window. This is mandatory because ALU flags lag ALUOut.
  - Counter == RES_LAT: capture alu ALUOut into rsp_result.
  - Counter == FLAG_LAT: capture alu flags into rsp_flags.
  - Also at counter == FLAG_LAT: carry_q <= flags[2] and go to RESP.
- Latency: accept edge to rsp_valid high = 1 + FLAG_LAT + 1 edges (5 with defaults). Throughput is 1 op per 5 cycles plus RESP wait.
- RESP: rsp_valid=1; rsp_result and rsp_flags are held stable until rsp_valid && rsp_ready. Then go to IDLE.
  - No new request is accepted in the same cycle; req_ready=0 in RESP.
- After RESP, alu_funsel returns to NEUTRAL_FUNSEL; alu_a/alu_b hold their last values.
- carry_q updates only on op completion, never in PRIME or IDLE.
  - For ops where the ALU leaves C = cin (logic and pass ops), carry_q becomes the resolved cin.
- req_op accepts all 32 codes with no illegal-op path. 16-bit ops (op[4]=0) return the ALU's sign-extended 32-bit result unchanged.
- Parameter constraint: RES_LAT < FLAG_LAT, both >= 1. The counter is wide enough for FLAG_LAT and saturates only on state exit.
- Back-to-back: a request held valid while busy stays pending. It is accepted on the first IDLE cycle after the response handshake.

Decomposition:
- Shared package alu_pkg holds:
  - FunSel localparams for all 32 codes (e.g. ADD32=5'b10100, ADDC32=5'b10101, SUB32=5'b10110, LSL16=5'b01011).
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
  - The state encoding.
- Single module with no sub-module. The latency counter is inline.

Test Plan:
- Reset mid-EXEC: issue ADD32, assert reset on 2nd EXEC cycle -> no rsp_valid ever; busy=0, carry_q=0, alu_funsel=5'b10000 on the next cycle.
- ADD32 wrap: a=32'hFFFF_FFFF, b=1, use_carry=0 -> rsp_result=0, rsp_flags=4'b1100, carry_q=1, rsp_valid exactly 5 edges after accept.
- Carry chain: after the previous test, ADDC32 with a=0, b=0, use_carry=1 -> rsp_result=1, rsp_flags[3]=0, carry_q=0.
- 16-bit sign extension: ADD16 with a=32'h0000_7FFF, b=1 -> rsp_result=32'hFFFF_8000, rsp_flags=4'b0011 (N=1, V=1).
- Backpressure: hold rsp_ready=0 for 10 cycles after SUB32 a=5, b=3 -> rsp_valid, rsp_result=2, rsp_flags=4'b0100 stay stable; req_ready=0 throughout; a queued request is accepted only after the handshake.
- Shift carry: CSL32 a=32'h8000_0001, use_carry=0, req_cin=1 -> rsp_result=32'h0000_0003, rsp_flags[2]=1, carry_q=1.
